// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS-subset core.
//   - opcode / funct encodings of the supported instructions
//   - FSM state enum (state_t) and ALU operation enum (alu_op_t)
//   - helpers that classify and translate R-type funct fields
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        EXEC, ALU_WB, BRANCH, JUMP, TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    function automatic alu_op_t funct_to_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational 32-bit ALU of the multicycle core.
// Ports:
//   a, b    in   32  operands
//   op      in       operation (add, sub, and, or, signed slt)
//   result  out  32  wrap-around result
//   zero    out   1  result == 0 (used for the beq compare)
module mc_alu
    import mc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: self-sequencing multicycle MIPS-subset core with a unified
// word memory port. Holds PC, IR, A, B, MDR, ALUOut and the register file.
// Ports:
//   clk, reset (async, active low)
//   mem_req/mem_we/mem_addr/mem_wdata  out  memory request
//   mem_rdata/mem_ready                in   memory response
//   alu_out      out  ALUOut register
//   trap         out  illegal instruction decoded (terminal until reset)
//   cycle_count, instr_count  out  performance counters
//   dbg_state    out  current FSM state
// Build option: MC_PERF_CNT_EN enables the counters; otherwise they read 0.
module multicycle_core
    import mc_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 32,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic [31:0]          alu_out,
    output logic                 trap,
    output logic [31:0]          cycle_count,
    output logic [31:0]          instr_count,
    output logic [3:0]           dbg_state
);

    localparam logic [ADDR_SIZE-1:0] PC_STEP   = ADDR_SIZE'(4);
    localparam logic [ADDR_SIZE-1:0] WORD_MASK = ~ADDR_SIZE'(3);

    state_t               state, next_state;
    logic [ADDR_SIZE-1:0] pc;
    logic [31:0]          ir, a_q, b_q, mdr, alu_out_q;
    logic [31:0]          rf [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, pc32, jump_target, rs_val, rt_val;

    assign opcode      = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign funct       = ir[5:0];
    assign imm_sext    = {{16{ir[15]}}, ir[15:0]};
    assign pc32        = 32'(pc);
    assign jump_target = {pc32[31:28], ir[25:0], 2'b00};
    assign rs_val      = (rs == 5'd0) ? 32'h0 : rf[rs];
    assign rt_val      = (rt == 5'd0) ? 32'h0 : rf[rt];

    logic [31:0] alu_a, alu_b, alu_result;
    alu_op_t     alu_op;
    logic        alu_zero;

    mc_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always_comb begin
        next_state = state;
        alu_a      = a_q;
        alu_b      = b_q;
        alu_op     = ALU_ADD;
        rf_we      = 1'b0;
        rf_waddr   = rt;
        rf_wdata   = alu_out_q;
        case (state)
            FETCH:  if (mem_ready) next_state = DECODE;
            DECODE: begin
                // Branch target is computed speculatively while decoding.
                alu_a = pc32;
                alu_b = {imm_sext[29:0], 2'b00};
                case (opcode)
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_ADDI:      next_state = EXEC;
                    OP_RTYPE:     next_state = funct_legal(funct) ? EXEC : TRAP;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    default:      next_state = TRAP;
                endcase
            end
            MEM_ADDR: begin
                alu_b      = imm_sext;
                next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: if (mem_ready) next_state = MEM_WB;
            MEM_WB: begin
                rf_wdata   = mdr;
                rf_we      = (rt != 5'd0);
                next_state = FETCH;
            end
            MEM_WR: if (mem_ready) next_state = FETCH;
            EXEC: begin
                if (opcode == OP_RTYPE) alu_op = funct_to_op(funct);
                else                    alu_b  = imm_sext;
                next_state = ALU_WB;
            end
            ALU_WB: begin
                rf_waddr   = (opcode == OP_RTYPE) ? rd : rt;
                rf_we      = (rf_waddr != 5'd0);
                next_state = FETCH;
            end
            BRANCH: begin
                alu_op     = ALU_SUB;
                next_state = FETCH;
            end
            JUMP:    next_state = FETCH;
            TRAP:    next_state = TRAP;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            pc        <= RESET_PC[ADDR_SIZE-1:0];
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mdr       <= '0;
            alu_out_q <= '0;
        end else begin
            state <= next_state;
            case (state)
                FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + PC_STEP;
                end
                DECODE: begin
                    a_q       <= rs_val;
                    b_q       <= rt_val;
                    alu_out_q <= alu_result;
                end
                MEM_ADDR, EXEC: alu_out_q <= alu_result;
                MEM_RD: if (mem_ready) mdr <= mem_rdata;
                BRANCH: if (alu_zero) pc <= alu_out_q[ADDR_SIZE-1:0];
                JUMP:   pc <= jump_target[ADDR_SIZE-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    // Memory handshake: a request is presented while mem_req=1 and completes
    // on the rising edge where mem_ready=1; until then state, PC, ALUOut and B
    // are frozen, so address, direction and write data stay stable. mem_ready
    // outside a request is ignored. The outputs are gated by reset so that an
    // access in flight is dropped the instant reset asserts.
    logic                 req_state;
    logic [ADDR_SIZE-1:0] addr_raw;

    assign req_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign addr_raw  = (state == FETCH) ? pc : alu_out_q[ADDR_SIZE-1:0];
    assign mem_req   = reset && req_state;
    assign mem_we    = reset && (state == MEM_WR);
    assign mem_addr  = (reset && req_state) ? (addr_raw & WORD_MASK) : '0;
    assign mem_wdata = (reset && (state == MEM_WR)) ? b_q : '0;

    assign alu_out   = alu_out_q;
    assign trap      = (state == TRAP);
    assign dbg_state = state;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_q, instr_q;

    // An instruction retires whenever the FSM re-enters FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if ((next_state == FETCH) && (state != FETCH)) instr_q <= instr_q + 32'd1;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multicycle MIPS-subset processor core: integrated control FSM, register file, ALU and instruction/ALU/memory-data holding registers, driving one unified word memory port through a ready handshake. It replaces the separate datapath-plus-external-control arrangement with a self-sequencing core. Memory wait states are tolerated at every access, and illegal instructions trap.

## Interface
- `ADDR_SIZE`, 32: byte-address and PC width, 16..32; jump targets and memory addresses are truncated to this width.
- `RESET_PC`, 0: PC value loaded on reset; word-aligned.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  ADDR_SIZE  byte address, bits [1:0] always 0.
- `mem_wdata`  out  32  store data.
- `mem_rdata`  in  32  read data, sampled on the edge where `mem_ready`=1.
- `mem_ready`  in  1  completes the pending access at this edge.
- `alu_out`  out  32  ALUOut register contents.
- `trap`  out  1  sticky; illegal opcode or funct was decoded.
- `cycle_count`  out  32  performance counter (see Configuration).
- `instr_count`  out  32  retired-instruction counter (see Configuration).

## Operation
- ISA:
  - R-type (op 000000) with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed).
  - op 100011 lw; 101011 sw; 000100 beq; 000010 j; 001000 addi.
  - Any other op/funct is illegal.
- Arithmetic: 32-bit, wrap-around, no overflow exception. The 16-bit immediate is sign-extended.
- Register 0 reads as 0; writes to it are discarded.
- FSM states: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, JUMP, TRAP.
- FETCH: request read at PC. On `mem_ready`: IR <= `mem_rdata`, PC <= PC+4, go to DECODE.
- DECODE: read registers rs/rt into A/B; ALUOut <= PC + (sext(imm)<<2). Dispatch:
  - lw/sw -> MEM_ADDR
  - R-type/addi -> EXEC
  - beq -> BRANCH
  - j -> JUMP
  - illegal -> TRAP
- MEM_ADDR: ALUOut <= A + sext(imm). lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: read at ALUOut. On ready: MDR <= `mem_rdata`, go to MEM_WB.
- MEM_WB: rt <= MDR; go to FETCH.
- MEM_WR: write B at ALUOut. On ready, go to FETCH.
- EXEC: ALUOut <= A op B (R-type) or A + sext(imm) (addi); go to ALU_WB.
- ALU_WB: write rd (R-type) or rt (addi); go to FETCH.
- BRANCH: if A == B, PC <= ALUOut; go to FETCH.
- JUMP: PC <= {PC[31:28], target26, 2'b00}[ADDR_SIZE-1:0]; go to FETCH.
- TRAP: `trap`=1, no memory requests, terminal until reset.
- Misaligned effective addresses: low two bits dropped silently, no trap.

## Timing
- Reset values:
  - FSM = FETCH, PC = `RESET_PC`; IR, A, B, MDR, ALUOut = 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `trap`=0, counters = 0.
  - Register file is not reset.
- `mem_req` is asserted only in FETCH, MEM_RD and MEM_WR.
- While `mem_req`=1, `mem_addr`, `mem_we` and `mem_wdata` are held stable until the edge where `mem_ready`=1. `mem_req` drops the next cycle unless the following state also requests.
- `mem_ready` while `mem_req`=0 is ignored.
- Zero-wait cycles per instruction: lw 5, sw 4, R-type/addi 4, beq 3, j 3. Each wait cycle adds exactly 1.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronous); any partial access is abandoned.
- `alu_out` updates one edge after the state that writes ALUOut.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - `cycle_count` increments every cycle out of reset, including in TRAP.
  - `instr_count` increments on entry to FETCH from MEM_WB, MEM_WR, ALU_WB, BRANCH or JUMP.
  - Both counters are 32-bit and wrap.
- Not defined: both outputs are tied to 0 and no counter flops are generated.

## Structure
- Package `mc_pkg`: opcode and funct constants, FSM state enum, ALU operation enum (ADD, SUB, AND, OR, SLT).
- One sub-module: `mc_alu`, combinational, 32-bit, inputs a/b/op, outputs result and zero.
- Register file, PC, IR, MDR, A, B and ALUOut stay inline in `multicycle_core`.

## Test plan
- Reset with `RESET_PC`=0x40: first `mem_req` reads 0x40 with `mem_we`=0; PC = 0x44 after the fetch completes.
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sw $3,0x10($0) -> write 0x00000002 to address 0x10. With zero wait the store completes 16 cycles after reset release.
- lw with `mem_ready` held low 3 cycles: address and `mem_we` stay stable, the load completes 3 cycles later than zero-wait, and the correct register value is observed.
- beq $1,$1,-1 -> PC returns to the branch address. beq with unequal operands -> PC+4. j 0x0000100 -> PC = 0x400.
- Opcode 111111 -> `trap`=1 after DECODE; `mem_req` stays 0; asynchronous reset clears the trap and restarts fetch.
- With `MC_PERF_CNT_EN`: after 3 zero-wait addi instructions, `instr_count`=3 and `cycle_count`=12 (counted from reset release). Without the macro, both counters read 0.
